// File: rtl/serial_divider_pkg.sv
// Shared types and constants for the serial restoring divider.
package serial_divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinish
  } div_state_e;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;
  localparam int unsigned DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

  // Step counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_divider_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import serial_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial   = {rem_i, bit_i};
    diff    = trial - {1'b0, divisor_i};
    // rem_i < divisor_i keeps trial < 2*divisor, so the MSB is a pure borrow flag.
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/serial_divider.sv
// Sequential restoring divider with start/busy/done handshake.
// Define DIV_EARLY_EXIT_EN to finish immediately when dividend < divisor.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             dbz_flag_q, dbz_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    divisor_d     = divisor_q;
    count_d       = count_q;
    dbz_flag_d    = dbz_flag_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    unique case (state_q)
      StIdle, StFinish: begin
        // FINISH publishes the working registers; results then hold through IDLE.
        if (state_q == StFinish) begin
          done_d        = 1'b1;
          quotient_d    = quo_q;
          remainder_d   = rem_q;
          div_by_zero_d = dbz_flag_q;
        end
        state_d = StIdle;
        if (start) begin
          divisor_d  = divisor;
          dbz_flag_d = 1'b0;
          count_d    = '0;
          if (divisor == '0) begin
            state_d    = StFinish;
            quo_d      = '1;
            rem_d      = dividend;
            dbz_flag_d = 1'b1;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend < divisor) begin
            state_d = StFinish;
            quo_d   = '0;
            rem_d   = dividend;
          end
`endif
          else begin
            state_d = StCalc;
            rem_d   = '0;
            quo_d   = dividend;
            count_d = CntW'(WIDTH - 1);
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q_bit};
        if (count_q == '0) begin
          state_d = StFinish;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StCalc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      count_q       <= '0;
      dbz_flag_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      divisor_q     <= divisor_d;
      count_q       <= count_d;
      dbz_flag_q    <= dbz_flag_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider (WIDTH=4).
module tb_serial_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  serial_divider #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one rising edge (edge k).
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Edges after edge k until done is seen (-1 on timeout), and busy samples before done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", remainder); end
  endtask

  task automatic test_basic();
    int lat, bc;
    launch(4'd13, 4'd3);
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("FAIL basic_q: got %0d want 4", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("FAIL basic_r: got %0d want 1", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("FAIL basic_q_hold: got %0d want 4", quotient); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    launch(4'd7, 4'd0);
    wait_done(lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy: got %0d want 0", bc); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("FAIL dbz_q: got %0d want 15", quotient); end
    checks++; if (remainder !== 4'd7) begin errors++; $display("FAIL dbz_r: got %0d want 7", remainder); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(4'd15, 4'd1);
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d want 5", lat); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("FAIL b2b_first_q: got %0d want 15", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL b2b_first_r: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b_first_dbz: got %b want 0", div_by_zero); end
    // Second start lands on the done cycle.
    launch(4'd15, 4'd15);
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_second_latency: got %0d want 5", lat); end
    checks++; if (quotient !== 4'd1) begin errors++; $display("FAIL b2b_second_q: got %0d want 1", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL b2b_second_r: got %0d want 0", remainder); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat, bc, extra;
    launch(4'd12, 4'd5);
    tick();
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ignore_latency: got %0d want 3", lat); end
    checks++; if (quotient !== 4'd2) begin errors++; $display("FAIL ignore_q: got %0d want 2", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("FAIL ignore_r: got %0d want 2", remainder); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_single_done: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    launch(4'd11, 4'd3);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL areset_q: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL areset_r: got %0d want 0", remainder); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b want 0", done); end
    tick();
    rst = 1'b0;
    tick();
    launch(4'd11, 4'd3);
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL areset_latency: got %0d want 5", lat); end
    checks++; if (quotient !== 4'd3) begin errors++; $display("FAIL areset_q_after: got %0d want 3", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("FAIL areset_r_after: got %0d want 2", remainder); end
    tick();
  endtask

  task automatic test_small_dividend();
    int lat, bc, exp_lat;
`ifdef DIV_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 5;
`endif
    launch(4'd2, 4'd9);
    wait_done(lat, bc);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL small_latency: got %0d want %0d", lat, exp_lat); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL small_q: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("FAIL small_r: got %0d want 2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL small_dbz: got %b want 0", div_by_zero); end
    tick();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_small_dividend();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_divider.md
Name: serial_divider

Overview:
- Sequential restoring divider; the inverse of the nibble adder datapath. Takes an unsigned dividend and divisor and produces quotient and remainder using one shift-subtract step per clock.
- Sits beside the adder in the same tile wrapper. Operands come from the switch nibbles (dividend = ui_in[3:0], divisor = ui_in[7:4]); results drive the display outputs.
- Start/busy/done handshake lets the wrapper trigger one division at a time.

Parameters:
- WIDTH, 4, operand/result width in bits (legal 2..8).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk.
- dividend  input  WIDTH  unsigned dividend, captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor, captured when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with done when divisor was 0.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - busy, done, div_by_zero, quotient, remainder, internal count and registers all 0.
- States: IDLE, CALC, FINISH.
- Start acceptance:
  - start is accepted in IDLE or FINISH.
  - In CALC, start is ignored; operands are not re-captured.
- IDLE/FINISH with start=1 at edge k:
  - Capture operands.
  - divisor==0: go to FINISH. At edge k+1, done=1, div_by_zero=1, quotient=all ones, remainder=dividend.
  - Otherwise: go to CALC, busy=1, partial remainder R=0, shift register Q=dividend, count=WIDTH-1.
- CALC, each edge:
  - T = {R[WIDTH-2:0], Q[WIDTH-1]}; Q shifts left.
  - If T >= divisor: R = T - divisor and new Q LSB = 1.
  - Else: R = T and new Q LSB = 0.
  - Compare and subtract use a WIDTH+1-bit difference; no overflow is possible.
  - When count==0, go to FINISH. Otherwise decrement count.
- FINISH entry:
  - done=1 for exactly one cycle; busy=0.
  - quotient=Q and remainder=R, held until the next accepted start.
  - div_by_zero=0 unless the divisor was 0.
- Latency: start at edge k → done high after edge k+WIDTH+1 (5 cycles for WIDTH=4).
- FINISH with no start returns to IDLE; outputs hold.
- Back-to-back: start on the done cycle is accepted and behaves as in IDLE.
- Outputs are registered; no combinational path from start to busy or done.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: at acceptance, if divisor!=0 and dividend<divisor, skip CALC and go to FINISH. done is high after edge k+1, quotient=0, remainder=dividend.
- Undefined: every nonzero-divisor operation takes the full WIDTH CALC cycles. Results are identical either way; only latency differs.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CALC, FINISH);
  - DIV_WIDTH_DEFAULT=4;
  - counter width constant $clog2(WIDTH).
- One sub-module, div_step: combinational. Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder, quotient bit. It is instantiated once and reused each CALC cycle.

Test Plan:
- 13/3 (WIDTH=4): start one cycle → busy 4 cycles, done exactly 5 cycles after start, quotient=4, remainder=1, div_by_zero=0.
- 7/0: done 1 cycle after start, div_by_zero=1, quotient=15, remainder=7; busy never asserted.
- 15/1 then 15/15 back-to-back (second start on done cycle): first result q=15 r=0, second q=1 r=0 five cycles later.
- 12/5 with start re-pulsed at CALC cycle 2 and operands changed to 9/2: ignored, result q=2 r=2, single done pulse.
- rst pulsed during CALC of 11/3: all outputs 0 immediately (async); after release a new 11/3 completes with q=3 r=2.
- 2/9: without DIV_EARLY_EXIT_EN done at 5 cycles; with it done at 1 cycle; both give q=0 r=2.
